// File: rtl/vga_frame_capture.sv
// Captures one WIN_W x WIN_H window of an incoming VGA pixel stream into a row-major image RAM.
// Optional CAPTURE_EDGE_EN: write a horizontal edge map (pixel != previous active pixel) instead of raw pixels.
module vga_frame_capture #(
   parameter int unsigned WIN_X0 = 200,
   parameter int unsigned WIN_Y0 = 200,
   parameter int unsigned WIN_W  = 100,
   parameter int unsigned WIN_H  = 100,
   parameter int unsigned ADDR_W = 14,
   parameter int unsigned PIX_W  = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              arm,
   input  logic              vs_n,
   input  logic              de,
   input  logic [PIX_W-1:0]  pixel,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [PIX_W-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic              frame_err
);

   localparam int unsigned POS_W = 10;
   localparam logic [POS_W-1:0]  X_LO   = POS_W'(WIN_X0);
   localparam logic [POS_W-1:0]  X_HI   = POS_W'(WIN_X0 + WIN_W);
   localparam logic [POS_W-1:0]  Y_LO   = POS_W'(WIN_Y0);
   localparam logic [POS_W-1:0]  Y_HI   = POS_W'(WIN_Y0 + WIN_H);
   localparam logic [POS_W-1:0]  POS_MX = '1;
   localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(WIN_W * WIN_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_CAPTURE, S_DONE} state_t;

   state_t             r_state, w_state_nxt;
   logic               r_vs_q, r_de_q;
   logic [POS_W-1:0]   r_col, r_row;
   logic [ADDR_W-1:0]  r_wcnt, w_wcnt_nxt;
   logic               r_frame_err, w_err_nxt;
   logic               r_wr_en, w_wr;
   logic [ADDR_W-1:0]  r_wr_addr;
   logic [PIX_W-1:0]   r_wr_data, w_wdata;
   logic               r_busy, r_done;
   logic               w_vs_fall, w_de_fall, w_in_win;

   assign w_vs_fall = r_vs_q & ~vs_n;
   assign w_de_fall = r_de_q & ~de;
   assign w_in_win  = de & (r_col >= X_LO) & (r_col < X_HI) & (r_row >= Y_LO) & (r_row < Y_HI);

`ifdef CAPTURE_EDGE_EN
   logic [PIX_W-1:0] r_prev_pix;

   // Previous active pixel, tracked across line boundaries
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  r_prev_pix <= '0;
      else if (de) r_prev_pix <= pixel;
   end

   assign w_wdata = (pixel != r_prev_pix) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
   assign w_wdata = pixel;
`endif

   // Sync edge registers and saturating active-area position counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vs_q <= 1'b0;
         r_de_q <= 1'b0;
         r_col  <= '0;
         r_row  <= '0;
      end else begin
         r_vs_q <= vs_n;
         r_de_q <= de;
         if (w_de_fall)                 r_col <= '0;
         else if (de && r_col != POS_MX) r_col <= r_col + POS_W'(1);
         if (w_vs_fall)                        r_row <= '0;
         else if (w_de_fall && r_row != POS_MX) r_row <= r_row + POS_W'(1);
      end
   end

   // State register and registered write port / status
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_wcnt      <= '0;
         r_frame_err <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wcnt      <= w_wcnt_nxt;
         r_frame_err <= w_err_nxt;
         r_wr_en     <= w_wr;
         if (w_wr) begin
            r_wr_addr <= r_wcnt;
            r_wr_data <= w_wdata;
         end
         r_busy <= (w_state_nxt == S_WAIT_VS) || (w_state_nxt == S_CAPTURE);
         r_done <= (w_state_nxt == S_DONE);
      end
   end

   // Next-state logic; a sync fall during capture restarts the window on the new frame
   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_err_nxt   = r_frame_err;
      w_wr        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (arm) begin
               w_state_nxt = S_WAIT_VS;
               w_err_nxt   = 1'b0;
            end
         end
         S_WAIT_VS: begin
            if (w_vs_fall) begin
               w_state_nxt = S_CAPTURE;
               w_wcnt_nxt  = '0;
            end
         end
         S_CAPTURE: begin
            if (w_vs_fall) begin
               w_err_nxt  = 1'b1;
               w_wcnt_nxt = '0;
            end else if (w_in_win) begin
               w_wr = 1'b1;
               if (r_wcnt == LAST) w_state_nxt = S_DONE;
               else                w_wcnt_nxt  = r_wcnt + ADDR_W'(1);
            end
         end
         S_DONE: begin
            if (arm) begin
               w_state_nxt = S_WAIT_VS;
               w_err_nxt   = 1'b0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign busy      = r_busy;
   assign done      = r_done;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture using a reduced window/frame geometry to keep runs short.
module tb_vga_frame_capture;

   localparam int unsigned X0 = 5, Y0 = 4, W = 6, H = 5, AW = 5, PW = 24;
   localparam int LW = 16;   // active pixels per line
   localparam int NL = 12;   // active lines per frame
   localparam int EC = 7;    // odd column for the edge-map pattern

   logic          clk = 1'b0;
   logic          reset, arm, vs_n, de;
   logic [PW-1:0] pixel;
   logic          wr_en, busy, done, frame_err;
   logic [AW-1:0] wr_addr;
   logic [PW-1:0] wr_data;

   int n_checks = 0, n_errors = 0;
   int wr_cnt = 0, mon_exp = 0;
   bit expect_wr = 0;
   int base;

   vga_frame_capture #(.WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(W), .WIN_H(H), .ADDR_W(AW), .PIX_W(PW)) dut (
      .clk(clk), .reset(reset), .arm(arm), .vs_n(vs_n), .de(de), .pixel(pixel),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .frame_err(frame_err)
   );

   always #20 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] pix_of(input int r, input int c);
`ifdef CAPTURE_EDGE_EN
      return (c == EC) ? 24'hABCDEF : 24'h123456;
`else
      return PW'(r * 256 + c);
`endif
   endfunction

   function automatic logic [PW-1:0] exp_data(input int a);
`ifdef CAPTURE_EDGE_EN
      int c;
      c = int'(X0) + a % int'(W);
      return (c == EC || c == EC + 1) ? 24'hFFFFFF : 24'h000000;
`else
      return pix_of(int'(Y0) + a / int'(W), int'(X0) + a % int'(W));
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One frame: sync pulse, back porch, nl lines of LW pixels; optional one-cycle arm at line start
   task automatic frame(input int nl, input int arm_line);
      vs_n = 1'b0; de = 1'b0; repeat (2) tick();
      vs_n = 1'b1; repeat (2) tick();
      for (int r = 0; r < nl; r++) begin
         for (int c = 0; c < LW; c++) begin
            de = 1'b1; pixel = pix_of(r, c); arm = (r == arm_line && c == 0);
            tick();
         end
         de = 1'b0; arm = 1'b0;
         repeat (3) tick();
      end
   endtask

   task automatic arm_pulse();
      arm = 1'b1; tick(); arm = 1'b0;
   endtask

   // Write-stream monitor on the falling edge
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         wr_cnt++;
         if (!expect_wr) check("unexpected_wr", 32'(wr_addr), 32'hFFFF_FFFF);
         check("wr_addr", 32'(wr_addr), 32'(mon_exp));
         check("wr_data", 32'(wr_data), 32'(exp_data(mon_exp)));
         mon_exp++;
      end
   end

   initial begin
      reset = 1'b0; arm = 1'b0; vs_n = 1'b1; de = 1'b0; pixel = '0;
      repeat (2) tick();
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      reset = 1'b1; tick();

      // Normal capture
      arm_pulse();
      check("armed_busy", 32'(busy), 1);
      expect_wr = 1; mon_exp = 0; base = wr_cnt;
      frame(NL, -1);
      check("norm_count", 32'(wr_cnt - base), 32'(W * H));
      check("norm_done", 32'(done), 1);
      check("norm_busy", 32'(busy), 0);
      check("norm_err", 32'(frame_err), 0);

      // Arm mid-frame from DONE: nothing until next sync fall
      expect_wr = 0; base = wr_cnt;
      frame(NL, 2);
      check("midarm_count", 32'(wr_cnt - base), 0);
      check("midarm_busy", 32'(busy), 1);
      check("midarm_done", 32'(done), 0);

      // Next frame captures; arm pulse inside the window is ignored
      expect_wr = 1; mon_exp = 0; base = wr_cnt;
      frame(NL, int'(Y0) + 1);
      check("busyarm_count", 32'(wr_cnt - base), 32'(W * H));
      check("busyarm_done", 32'(done), 1);

      // Truncated frame: two window rows, then a new sync fall
      arm_pulse();
      expect_wr = 1; mon_exp = 0; base = wr_cnt;
      frame(int'(Y0) + 2, -1);
      check("trunc_count", 32'(wr_cnt - base), 32'(2 * W));
      check("trunc_busy", 32'(busy), 1);
      check("trunc_err_pre", 32'(frame_err), 0);
      mon_exp = 0; base = wr_cnt;
      frame(NL, -1);
      check("retry_count", 32'(wr_cnt - base), 32'(W * H));
      check("retry_done", 32'(done), 1);
      check("retry_err", 32'(frame_err), 1);

      // Re-arm clears the sticky error
      arm_pulse();
      check("rearm_err", 32'(frame_err), 0);
      check("rearm_busy", 32'(busy), 1);

      // Reset mid-capture
      mon_exp = 0;
      frame(int'(Y0) + 2, -1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midrst_wr_en", 32'(wr_en), 0);
      check("midrst_wr_addr", 32'(wr_addr), 0);
      check("midrst_wr_data", 32'(wr_data), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_err", 32'(frame_err), 0);
      tick();
      reset = 1'b1;
      expect_wr = 0; base = wr_cnt;
      frame(NL, -1);
      check("postrst_count", 32'(wr_cnt - base), 0);
      check("postrst_busy", 32'(busy), 0);
      check("postrst_done", 32'(done), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Sink-side counterpart of the VGA display path.
- Watches an incoming 640x480 VGA-style pixel stream (vs_n, de, 24-bit RGB), all in the 25 MHz pixel clock domain.
- On request, captures one rectangular window of one frame and writes it into the 100x100 image RAM.
- Write addressing is row-major: addr = WIN_W*(row-WIN_Y0)+(col-WIN_X0). This is the same layout the display ROM/RAM reader uses, so a captured frame can be shown back unchanged.

Parameters:
- WIN_X0, 200, first captured column (active-pixel index)
- WIN_Y0, 200, first captured row (active-line index)
- WIN_W, 100, window width in pixels
- WIN_H, 100, window height in lines
- ADDR_W, 14, write address width; must satisfy 2^ADDR_W >= WIN_W*WIN_H
- PIX_W, 24, pixel width, {R[23:16],G[15:8],B[7:0]}

Ports:
- clk  in  1  pixel clock (25 MHz); all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- arm  in  1  capture request, sampled every cycle
- vs_n  in  1  vertical sync, active-low
- de  in  1  data enable, high during active pixels (same sense as VGA_BLANK_N)
- pixel  in  PIX_W  incoming pixel, valid when de=1
- wr_en  out  1  RAM write strobe, one cycle per captured pixel
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  PIX_W  RAM write data
- busy  out  1  high in WAIT_VS and CAPTURE
- done  out  1  high in DONE
- frame_err  out  1  sticky error flag, cleared on arm accepted

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, frame_err=0; all counters and edge registers = 0.
- Edge detect: vs_q, de_q are registered copies of vs_n and de.
  - vs_fall = vs_q & ~vs_n
  - de_fall = de_q & ~de
- Position counters (10 bits each, run in every state):
  - col increments on each de=1 cycle; clears on de_fall.
  - row increments on de_fall; clears on vs_fall.
  - Both saturate at 1023.
- in_win = de & (col>=WIN_X0) & (col<WIN_X0+WIN_W) & (row>=WIN_Y0) & (row<WIN_Y0+WIN_H).
- State machine:
  - IDLE: arm=1 -> WAIT_VS; clear frame_err.
  - WAIT_VS: vs_fall -> CAPTURE; load write counter wcnt=0.
  - CAPTURE: each in_win cycle writes one pixel and increments wcnt.
    - Write of wcnt=WIN_W*WIN_H-1 -> DONE.
    - vs_fall before that write: set frame_err=1 and go to CAPTURE again with wcnt=0. The capture restarts on the new frame.
  - DONE: done=1. arm=1 -> WAIT_VS (re-arm, clears frame_err, done drops next cycle). Otherwise hold.
- arm is ignored in WAIT_VS and CAPTURE. arm held high in DONE re-arms immediately.
- Write port, one-cycle latency: on a cycle with in_win in CAPTURE, the next cycle has wr_en=1, wr_addr=wcnt (pre-increment), wr_data=pixel as sampled. Otherwise wr_en=0; wr_addr and wr_data hold their last values.
- Address arithmetic: wcnt is ADDR_W bits and only ever reaches WIN_W*WIN_H-1; no wrap in normal use.
- Window outside active area (e.g. WIN_Y0+WIN_H>480): the last write never occurs. The next vs_fall sets frame_err and the block keeps retrying until reset. This is by design.
- Back-to-back frames: the DONE->WAIT_VS re-arm waits for the next vs_fall, so capture never begins mid-frame.

Optional Feature:
- Macro: CAPTURE_EDGE_EN.
- Defined: wr_data is a horizontal edge map instead of the raw pixel.
  - wr_data = {PIX_W{1'b1}} if pixel != prev_pix, else 0.
  - prev_pix is a PIX_W register loaded with pixel on every de=1 cycle, reset to 0.
  - The first window pixel of each row is therefore compared with the active pixel at col WIN_X0-1. For WIN_X0=0 it is compared with the last pixel of the previous line.
  - Addressing, latency and handshakes are unchanged.
- Not defined: wr_data = raw pixel; prev_pix is not instantiated.

Test Plan:
- Reset mid-capture: assert reset=0 at row 250 -> all outputs 0 within the same cycle, state IDLE; no wr_en until a new arm and vs_fall.
- Normal capture: pixel=row*256+col pattern, arm pulse, one full frame -> exactly 10000 wr_en pulses.
  - First write: addr 0, data 200*256+200.
  - Last write: addr 9999, data 299*256+299.
  - done=1 after the last write, busy=0.
- Arm mid-frame: arm at row 100 -> no writes until the next vs_fall; then capture completes with 10000 writes.
- Truncated frame: force vs_fall at window row 50 -> frame_err=1, wcnt restarts at 0; the next full frame completes with done=1 and frame_err still 1.
  - Re-arm -> frame_err=0.
- Arm ignored while busy: pulse arm during CAPTURE -> state, wcnt and the write stream are unaffected.
- With CAPTURE_EDGE_EN: stream of constant 24'h123456 except col 250 = 24'hABCDEF on every line.
  - Per window row, wr_data=FFFFFF at addresses row*100+50 and row*100+51.
  - All other addresses get 0.
